// File: rtl/grid_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module : grid_pkg
// Desc   : Grid geometry, cell encodings and scheduler state type.
// Rev    : 1.0
// ============================================================================
package grid_pkg;

    localparam int unsigned GRID_X_MAX = 10;
    localparam int unsigned GRID_Y_MAX = 8;
    localparam int unsigned COORD_W    = 4;
    localparam int unsigned VALUE_W    = 2;

    typedef enum logic [VALUE_W-1:0] {
        CELL_UNEXPLORED = 2'b00,
        CELL_VISITED    = 2'b01,
        CELL_WALL       = 2'b10,
        CELL_ROBOT      = 2'b11
    } cell_value_e;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_SERVE = 1'b1
    } state_e;

    function automatic logic coord_in_range(input logic [COORD_W-1:0] x,
                                            input logic [COORD_W-1:0] y);
        return (x <= COORD_W'(GRID_X_MAX)) && (y <= COORD_W'(GRID_Y_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/grid_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : grid_write_if
// Desc   : Requester handshakes plus grid-memory write port of the scheduler.
// Rev    : 1.0
// ============================================================================
interface grid_write_if;
    import grid_pkg::*;

    logic               clear;

    logic               r0_valid;
    logic [COORD_W-1:0] r0_x;
    logic [COORD_W-1:0] r0_y;
    logic [VALUE_W-1:0] r0_value;
    logic               r0_ack;

    logic               r1_valid;
    logic [COORD_W-1:0] r1_x;
    logic [COORD_W-1:0] r1_y;
    logic [VALUE_W-1:0] r1_value;
    logic               r1_ack;

    logic [COORD_W-1:0] X_COORD;
    logic [COORD_W-1:0] Y_COORD;
    logic [VALUE_W-1:0] VALUE;
    logic               ENABLE;
    logic               busy;
    logic               bad_coord;

    // Requesters / test environment side
    modport master (
        output clear,
        output r0_valid, r0_x, r0_y, r0_value,
        output r1_valid, r1_x, r1_y, r1_value,
        input  r0_ack, r1_ack,
        input  X_COORD, Y_COORD, VALUE, ENABLE, busy, bad_coord
    );

    // Scheduler side
    modport slave (
        input  clear,
        input  r0_valid, r0_x, r0_y, r0_value,
        input  r1_valid, r1_x, r1_y, r1_value,
        output r0_ack, r1_ack,
        output X_COORD, Y_COORD, VALUE, ENABLE, busy, bad_coord
    );

endinterface
`default_nettype wire

// File: rtl/grid_write_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter2
// Desc   : Two-input round-robin arbiter; prio_i=0 favours requester 0.
// Rev    : 1.0
// ============================================================================
module rr_arbiter2 (
    input  wire logic [1:0] req_i,
    input  wire logic       prio_i,
    output logic      [1:0] grant_o,
    output logic            prio_o
);

    logic [1:0] grant;

    always_comb begin
        grant = req_i;
        if (req_i == 2'b11) begin
            grant = prio_i ? 2'b10 : 2'b01;
        end
    end

    // Favour whichever requester was not just served; hold when idle.
    always_comb begin
        prio_o = prio_i;
        if (grant[0]) begin
            prio_o = 1'b1;
        end else if (grant[1]) begin
            prio_o = 1'b0;
        end
    end

    assign grant_o = grant;

endmodule
`default_nettype wire

// File: rtl/grid_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module : grid_write_scheduler
// Desc   : Arbitrates two grid-write requesters and runs full-grid clear sweeps.
// Rev    : 1.0
// ============================================================================
module grid_write_scheduler
    import grid_pkg::*;
(
    input  wire logic   clk,
    input  wire logic   reset,
    grid_write_if.slave bus
);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] sweep_x_q, sweep_x_d;
    logic [COORD_W-1:0] sweep_y_q, sweep_y_d;
    logic               prio_q, prio_d;

    logic               en_q, en_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [VALUE_W-1:0] val_q, val_d;
    logic               busy_q, busy_d;
    logic               bad_q, bad_d;
    logic               ack0_q, ack0_d;
    logic               ack1_q, ack1_d;

    logic [1:0]         req;
    logic [1:0]         grant;
    logic               prio_next;
    logic [COORD_W-1:0] req_x;
    logic [COORD_W-1:0] req_y;
    logic [VALUE_W-1:0] req_val;

    // A requester whose ack is on the wire this cycle is still showing the
    // request just consumed, so it must not be granted again.
    assign req = {bus.r1_valid & ~ack1_q, bus.r0_valid & ~ack0_q};

    rr_arbiter2 u_arb (
        .req_i   (req),
        .prio_i  (prio_q),
        .grant_o (grant),
        .prio_o  (prio_next)
    );

    assign req_x   = grant[1] ? bus.r1_x     : bus.r0_x;
    assign req_y   = grant[1] ? bus.r1_y     : bus.r0_y;
    assign req_val = grant[1] ? bus.r1_value : bus.r0_value;

    always_comb begin
        state_d   = state_q;
        sweep_x_d = sweep_x_q;
        sweep_y_d = sweep_y_q;
        prio_d    = prio_q;
        en_d      = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        val_d     = val_q;
        busy_d    = 1'b0;
        bad_d     = 1'b0;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;

        case (state_q)
            ST_CLEAR: begin
                en_d   = 1'b1;
                busy_d = 1'b1;
                x_d    = sweep_x_q;
                y_d    = sweep_y_q;
                val_d  = CELL_UNEXPLORED;
                if (sweep_x_q == COORD_W'(GRID_X_MAX)) begin
                    sweep_x_d = '0;
                    if (sweep_y_q == COORD_W'(GRID_Y_MAX)) begin
                        sweep_y_d = '0;
                        state_d   = ST_SERVE;
                    end else begin
                        sweep_y_d = sweep_y_q + 1'b1;
                    end
                end else begin
                    sweep_x_d = sweep_x_q + 1'b1;
                end
            end

            ST_SERVE: begin
                if (bus.clear) begin
                    state_d   = ST_CLEAR;
                    sweep_x_d = '0;
                    sweep_y_d = '0;
                end else if (grant != 2'b00) begin
                    ack0_d = grant[0];
                    ack1_d = grant[1];
                    prio_d = prio_next;
                    if (coord_in_range(req_x, req_y)) begin
                        en_d  = 1'b1;
                        x_d   = req_x;
                        y_d   = req_y;
                        val_d = req_val;
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            sweep_x_q <= '0;
            sweep_y_q <= '0;
            prio_q    <= 1'b0;
            en_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            val_q     <= '0;
            busy_q    <= 1'b0;
            bad_q     <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sweep_x_q <= sweep_x_d;
            sweep_y_q <= sweep_y_d;
            prio_q    <= prio_d;
            en_q      <= en_d;
            x_q       <= x_d;
            y_q       <= y_d;
            val_q     <= val_d;
            busy_q    <= busy_d;
            bad_q     <= bad_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
        end
    end

    assign bus.ENABLE    = en_q;
    assign bus.X_COORD   = x_q;
    assign bus.Y_COORD   = y_q;
    assign bus.VALUE     = val_q;
    assign bus.busy      = busy_q;
    assign bus.bad_coord = bad_q;
    assign bus.r0_ack    = ack0_q;
    assign bus.r1_ack    = ack1_q;

endmodule
`default_nettype wire

// File: doc/grid_write_scheduler.md
GRID_WRITE_SCHEDULER -- requirements
Module: grid_write_scheduler

Interface
REQ-001 The module SHALL expose these ports:
  clk        in   1  sole clock, all logic on rising edge
  reset      in   1  synchronous, active-high
  clear      in   1  single-cycle pulse; request full-grid clear sweep
  r0_valid   in   1  requester 0 (radio decoder) write request
  r0_x       in   4  requester 0 column
  r0_y       in   4  requester 0 row
  r0_value   in   2  requester 0 cell value
  r0_ack     out  1  one-cycle pulse; requester 0 request consumed
  r1_valid, r1_x, r1_y, r1_value, r1_ack  same as r0_*, for requester 1 (local/test generator)
  X_COORD    out  4  grid memory write column
  Y_COORD    out  4  grid memory write row
  VALUE      out  2  grid memory write data
  ENABLE     out  1  grid memory write strobe, one write per high cycle
  busy       out  1  high while the clear sweep runs
  bad_coord  out  1  one-cycle pulse; consumed request was out of range and dropped
REQ-002 The module SHALL have one clock (clk) and a synchronous, active-high reset (reset).
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 The grid SHALL be 11 columns (x 0..10) by 9 rows (y 0..8), for 99 cells.
REQ-005 The FSM SHALL have two states, CLEAR and SERVE.
REQ-006 In CLEAR, the module SHALL issue one write per cycle with ENABLE=1 and VALUE=2'b00.
REQ-007 The CLEAR sweep SHALL run x-fastest from (0,0) to (10,8): x wraps 10->0 with y+1, and the sweep ends after (10,8).
REQ-008 The CLEAR sweep SHALL last exactly 99 consecutive ENABLE cycles.
REQ-009 After the write to (10,8), the FSM SHALL go to SERVE on the next cycle.
REQ-010 busy SHALL be 1 during every CLEAR write cycle and 0 otherwise.
REQ-011 In CLEAR, no ack SHALL be issued; requests stay pending.
REQ-012 A clear pulse received during CLEAR SHALL be ignored.
REQ-013 In SERVE, a requester SHALL be eligible when its valid=1 and its ack is not high in that cycle (this prevents a double grant of one request).
REQ-014 In SERVE, at most one grant SHALL be made per cycle.
REQ-015 When only one requester is eligible, that requester SHALL be granted.
REQ-016 When both requesters are eligible, the one not granted most recently SHALL be granted (round-robin).
REQ-017 After reset, requester 0 SHALL have priority for the first contended grant.
REQ-018 A grant sampled at cycle N SHALL produce the following at cycle N+1:
  - the granted requester's ack=1;
  - ENABLE=1, with X_COORD/Y_COORD/VALUE equal to the sampled x/y/value.
REQ-019 A requester SHALL hold valid and its data stable until its ack; it may deassert valid, or present a new request, in the ack cycle.
REQ-020 A granted request with x>10 or y>8 SHALL be acked with ENABLE=0 and bad_coord=1 at N+1 (request dropped).
REQ-021 A clear pulse sampled in SERVE SHALL take precedence over grants in that cycle.
REQ-022 When that clear pulse is sampled, the FSM SHALL enter CLEAR, with the first sweep write (0,0) one cycle later; any write already registered still completes.
REQ-023 When not writing, ENABLE SHALL be 0; X_COORD/Y_COORD/VALUE SHALL hold their last values.
REQ-024 ack and bad_coord SHALL be single-cycle pulses.

Reset
REQ-025 While reset=1, the outputs SHALL be: ENABLE=0, r0_ack=0, r1_ack=0, bad_coord=0, X_COORD=0, Y_COORD=0, VALUE=0, busy=0.
REQ-026 While reset=1, the round-robin pointer SHALL be set to favour requester 0.
REQ-027 After reset deasserts, the FSM SHALL start in CLEAR, and the first sweep write (0,0) SHALL occur on the first cycle with reset=0.
REQ-028 Reset asserted mid-sweep or mid-grant SHALL abandon the operation; the sweep restarts from (0,0).

Structure
REQ-029 The shared package grid_pkg SHALL hold:
  - GRID_X_MAX=10 and GRID_Y_MAX=8;
  - cell value encodings (2'b00 unexplored, 2'b01 visited, 2'b10 wall, 2'b11 robot);
  - the FSM state typedef.
REQ-030 The two-input round-robin arbiter SHALL be the sub-module rr_arbiter2 (inputs req[1:0]; outputs one-hot grant and pointer update).
REQ-031 The sweep counter and output registers SHALL reside in grid_write_scheduler.

Verification
REQ-032 Reset then idle: count the writes after reset falls -> 99 ENABLE cycles with VALUE=00, first (0,0), 12th (0,1), last (10,8); busy then falls and ENABLE stays 0.
REQ-033 Single request in SERVE: r0 (x=3, y=4, value=01) -> next cycle r0_ack=1, ENABLE=1, X_COORD=3, Y_COORD=4, VALUE=01; exactly one write.
REQ-034 Contention: r0 and r1 both held valid, each re-requesting after ack -> grants alternate r0,r1,r0,r1 and each requester receives exactly one ack per request.
REQ-035 Out-of-range request: r1 (x=11, y=2) -> r1_ack=1 and bad_coord=1 in the same cycle, with ENABLE=0.
REQ-036 Clear during traffic: clear pulse while r0 is valid -> no ack for 99 sweep cycles, then r0 is acked and its write lands after the sweep.
REQ-037 Reset mid-sweep: assert reset at sweep write 40 -> outputs go to reset values; after release, the sweep restarts at (0,0) and totals 99 writes.
